// File: rtl/bsg_mem_1rw_sync_rv_adapter.sv
// bsg_mem_1rw_sync_rv_adapter: ready/valid front end for a 1rw synchronous RAM with a 2-entry response buffer
// Ports:
//   clk_i, reset_n_i                      clock, asynchronous active-low reset
//   v_i, w_i, addr_i, data_i, ready_o     request side (accepted on v_i & ready_o)
//   v_o, data_o, yumi_i                   read response side (taken on yumi_i)
//   mem_v_o, mem_w_o, mem_addr_o,
//   mem_data_o, mem_data_i                RAM side; read data returns one cycle after issue
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
module bsg_mem_1rw_sync_rv_adapter #(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i
);
  logic [1:0]         occ_r;
  logic               rd_pending_r;
  logic               rd_ptr_r;
  logic               wr_ptr_r;
  logic [width_p-1:0] fifo_r [2];
  logic               has_head;
  logic               credit;
  logic               bypass;
  logic               enq;
  logic               deq;
  assign has_head = occ_r != 2'd0;
  // A read may only issue if a buffer slot is guaranteed for its return data.
  assign credit = ({1'b0, occ_r} + {2'b0, rd_pending_r}) < 3'd2;
  assign ready_o = w_i | credit;
  assign mem_v_o = reset_n_i & v_i & ready_o;
  assign mem_w_o = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = data_i;
  // Buffered data is older than data returning from the RAM, so the head wins.
  assign v_o = has_head | rd_pending_r;
  assign data_o = has_head ? fifo_r[rd_ptr_r] : mem_data_i;
  assign bypass = rd_pending_r & ~has_head;
  assign enq = rd_pending_r & ~(bypass & yumi_i);
  assign deq = yumi_i & has_head;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      occ_r        <= 2'd0;
      rd_pending_r <= 1'b0;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
    end else begin
      rd_pending_r <= mem_v_o & ~w_i;
      occ_r        <= occ_r + {1'b0, enq} - {1'b0, deq};
      wr_ptr_r     <= wr_ptr_r ^ enq;
      rd_ptr_r     <= rd_ptr_r ^ deq;
    end
  // Storage is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i)
    if (enq) fifo_r[wr_ptr_r] <= mem_data_i;
`ifndef SYNTHESIS
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted while v_o is low");
  a_no_x: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown({v_i, yumi_i}))
    else $error("X on v_i or yumi_i");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) ({1'b0, occ_r} + {2'b0, rd_pending_r}) <= 3'd2)
    else $error("response buffer overflow");
`endif
endmodule
